rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have no parameters; data width fixed at 64, register address width fixed at 5.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 lsu_valid / alu0_valid / alu1_valid  input  1 each  result offered by that unit.
REQ-005 lsu_ready / alu0_ready / alu1_ready  output  1 each  arbiter accepts that unit's result this cycle.
REQ-006 lsu_rd / alu0_rd / alu1_rd  input  5 each  destination register.
REQ-007 lsu_data / alu0_data / alu1_data  input  64 each  result value.
REQ-008 rf_bus_0_wen, rf_bus_1_wen  output  1 each  register-file write enables.
REQ-009 rf_bus_0_waddr, rf_bus_1_waddr  output  5 each  write addresses.
REQ-010 rf_bus_0_wdata, rf_bus_1_wdata  output  64 each  write data.
REQ-011 wb_idle  output  1  high when no entry is held and neither write port is enabled.

Function
REQ-012 SHALL hold one entry (held flag, rd, data) per source: lsu, alu0, alu1.
REQ-013 A handshake occurs on a rising edge when valid and ready are both high; the entry is captured into that source's holding register.
REQ-014 ready_x SHALL equal (!held_x || grant_x); ready SHALL NOT depend combinationally on any valid input.
REQ-015 Each cycle SHALL grant at most two held entries; grants are combinational from held state only.
REQ-016 Base priority: lsu > alu0 > alu1.
REQ-017 A 2-bit saturating counter alu1_wait SHALL increment each cycle alu1 is held and not granted, and SHALL clear when alu1 is granted or not held.
REQ-018 When alu1_wait == 3, priority becomes lsu > alu1 > alu0.
REQ-019 Highest-priority grant SHALL drive port 0; second grant SHALL drive port 1.
REQ-020 A candidate whose nonzero rd equals the port-0 grant's rd SHALL be skipped for port 1; the next candidate in priority order is considered.
REQ-021 On each rising edge, port-n outputs SHALL register the port-n grant: waddr = rd, wdata = data, wen = granted && (rd != 0).
REQ-022 An unused port SHALL drive wen = 0, waddr = 0, wdata = 0.
REQ-023 Granted entries with rd == 0 SHALL consume a slot and clear their held flag but SHALL produce no write.
REQ-024 A granted entry's held flag SHALL clear at the same edge its port output registers; a same-cycle new handshake on that source SHALL re-set the flag with the new values.
REQ-025 Latency: handshake at edge E0 -> earliest grant in cycle after E0 -> wen high in cycle after edge E1 -> register file written at edge E2.
REQ-026 Throughput: two writes per cycle sustained; with all three sources continuously valid, each source SHALL be granted at least once every 4 cycles.
REQ-027 wb_idle = !held_lsu && !held_alu0 && !held_alu1 && !rf_bus_0_wen && !rf_bus_1_wen.

Reset
REQ-028 While reset is high at a rising edge, all held flags, alu1_wait, and all port outputs SHALL clear to 0, and ready outputs SHALL be 1 in the following cycle.
REQ-029 Entries held when reset asserts mid-operation SHALL be discarded without any write.
REQ-030 Handshakes in a cycle where reset is high SHALL be ignored.

Verification
REQ-031 Single alu0 result rd=5, data=0x1234 -> exactly two edges later rf_bus_0_wen=1, waddr=5, wdata=0x1234; rf_bus_1_wen=0.
REQ-032 lsu(rd=3), alu0(rd=4), alu1(rd=6) all handshake together -> next output cycle: port0 = rd 3, port1 = rd 4; following cycle: port0 = rd 6.
REQ-033 lsu and alu0 both rd=7, alu1 rd=8 -> port0 = lsu rd 7, port1 = alu1 rd 8; alu0 rd 7 written on port0 the next cycle.
REQ-034 All three sources valid every cycle with distinct rds -> alu1 granted no later than its 4th held cycle; no source is ever starved.
REQ-035 alu1 result with rd=0 -> alu1_ready returns high, no wen asserted on either port, wb_idle returns to 1.
REQ-036 Reset asserted with all three entries held -> no subsequent wen; all ready = 1 and wb_idle = 1 one cycle after reset.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: holds one result per unit (lsu, alu0, alu1) and drains up to two
// per cycle onto the register-file write ports, with an aging boost for alu1.
module rf_wb_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [63:0] lsu_data,
    input  logic        alu0_valid,
    output logic        alu0_ready,
    input  logic [4:0]  alu0_rd,
    input  logic [63:0] alu0_data,
    input  logic        alu1_valid,
    output logic        alu1_ready,
    input  logic [4:0]  alu1_rd,
    input  logic [63:0] alu1_data,
    output logic        rf_bus_0_wen,
    output logic [4:0]  rf_bus_0_waddr,
    output logic [63:0] rf_bus_0_wdata,
    output logic        rf_bus_1_wen,
    output logic [4:0]  rf_bus_1_waddr,
    output logic [63:0] rf_bus_1_wdata,
    output logic        wb_idle
);

    logic        held_lsu_r, held_alu0_r, held_alu1_r;
    logic [4:0]  rd_lsu_r, rd_alu0_r, rd_alu1_r;
    logic [63:0] data_lsu_r, data_alu0_r, data_alu1_r;
    logic [1:0]  alu1_wait_r;

    logic [3:0]  cand_held_s;
    logic [4:0]  cand_rd_s [4];
    logic [63:0] cand_data_s [4];
    logic [1:0]  order_s [3];
    logic [1:0]  idx_s;
    logic [1:0]  g0_idx_s, g1_idx_s;
    logic        grant_lsu_s, grant_alu0_s, grant_alu1_s;

    // Pack the held entries into index-addressable candidates; slot 3 is the empty "no grant" entry.
    always_comb begin
        cand_held_s    = {1'b0, held_alu1_r, held_alu0_r, held_lsu_r};
        cand_rd_s[0]   = rd_lsu_r;
        cand_rd_s[1]   = rd_alu0_r;
        cand_rd_s[2]   = rd_alu1_r;
        cand_rd_s[3]   = 5'd0;
        cand_data_s[0] = data_lsu_r;
        cand_data_s[1] = data_alu0_r;
        cand_data_s[2] = data_alu1_r;
        cand_data_s[3] = 64'd0;
    end

    // Priority order; a starved alu1 jumps ahead of alu0.
    always_comb begin
        order_s[0] = 2'd0;
        if (alu1_wait_r == 2'd3) begin
            order_s[1] = 2'd2;
            order_s[2] = 2'd1;
        end else begin
            order_s[1] = 2'd1;
            order_s[2] = 2'd2;
        end
    end

    // Pick port-0 and port-1 grants; port 1 skips a candidate writing the same nonzero rd as port 0.
    always_comb begin
        g0_idx_s = 2'd3;
        g1_idx_s = 2'd3;
        idx_s    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            idx_s = order_s[k];
            if (!cand_held_s[idx_s]) begin
                g0_idx_s = g0_idx_s;
            end else if (g0_idx_s == 2'd3) begin
                g0_idx_s = idx_s;
            end else if ((g1_idx_s == 2'd3) &&
                         !((cand_rd_s[idx_s] != 5'd0) && (cand_rd_s[idx_s] == cand_rd_s[g0_idx_s]))) begin
                g1_idx_s = idx_s;
            end else begin
                g1_idx_s = g1_idx_s;
            end
        end
    end

    assign grant_lsu_s  = (g0_idx_s == 2'd0) || (g1_idx_s == 2'd0);
    assign grant_alu0_s = (g0_idx_s == 2'd1) || (g1_idx_s == 2'd1);
    assign grant_alu1_s = (g0_idx_s == 2'd2) || (g1_idx_s == 2'd2);

    assign lsu_ready  = !held_lsu_r  || grant_lsu_s;
    assign alu0_ready = !held_alu0_r || grant_alu0_s;
    assign alu1_ready = !held_alu1_r || grant_alu1_s;

    assign wb_idle = !held_lsu_r && !held_alu0_r && !held_alu1_r && !rf_bus_0_wen && !rf_bus_1_wen;

    // Holding registers: a new handshake overrides the clear caused by a grant in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_lsu_r  <= 1'b0;
            held_alu0_r <= 1'b0;
            held_alu1_r <= 1'b0;
            rd_lsu_r    <= 5'd0;
            rd_alu0_r   <= 5'd0;
            rd_alu1_r   <= 5'd0;
            data_lsu_r  <= 64'd0;
            data_alu0_r <= 64'd0;
            data_alu1_r <= 64'd0;
        end else begin
            if (lsu_valid && lsu_ready) begin
                held_lsu_r <= 1'b1;
                rd_lsu_r   <= lsu_rd;
                data_lsu_r <= lsu_data;
            end else if (grant_lsu_s) begin
                held_lsu_r <= 1'b0;
            end
            if (alu0_valid && alu0_ready) begin
                held_alu0_r <= 1'b1;
                rd_alu0_r   <= alu0_rd;
                data_alu0_r <= alu0_data;
            end else if (grant_alu0_s) begin
                held_alu0_r <= 1'b0;
            end
            if (alu1_valid && alu1_ready) begin
                held_alu1_r <= 1'b1;
                rd_alu1_r   <= alu1_rd;
                data_alu1_r <= alu1_data;
            end else if (grant_alu1_s) begin
                held_alu1_r <= 1'b0;
            end
        end
    end

    // alu1 aging counter, saturating at 3.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu1_wait_r <= 2'd0;
        end else if (held_alu1_r && !grant_alu1_s) begin
            if (alu1_wait_r != 2'd3) begin
                alu1_wait_r <= alu1_wait_r + 2'd1;
            end
        end else begin
            alu1_wait_r <= 2'd0;
        end
    end

    // Register the write ports; an absent grant selects the all-zero slot 3.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_bus_0_wen   <= 1'b0;
            rf_bus_0_waddr <= 5'd0;
            rf_bus_0_wdata <= 64'd0;
            rf_bus_1_wen   <= 1'b0;
            rf_bus_1_waddr <= 5'd0;
            rf_bus_1_wdata <= 64'd0;
        end else begin
            rf_bus_0_wen   <= (cand_rd_s[g0_idx_s] != 5'd0);
            rf_bus_0_waddr <= cand_rd_s[g0_idx_s];
            rf_bus_0_wdata <= cand_data_s[g0_idx_s];
            rf_bus_1_wen   <= (cand_rd_s[g1_idx_s] != 5'd0);
            rf_bus_1_waddr <= cand_rd_s[g1_idx_s];
            rf_bus_1_wdata <= cand_data_s[g1_idx_s];
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, multi-cycle sequences and a randomized
// run against a queue-based model of the write-back rules.
module tb_rf_wb_arbiter;

    logic        clock, reset;
    logic        lsu_valid, alu0_valid, alu1_valid;
    logic        lsu_ready, alu0_ready, alu1_ready;
    logic [4:0]  lsu_rd, alu0_rd, alu1_rd;
    logic [63:0] lsu_data, alu0_data, alu1_data;
    logic        rf_bus_0_wen, rf_bus_1_wen, wb_idle;
    logic [4:0]  rf_bus_0_waddr, rf_bus_1_waddr;
    logic [63:0] rf_bus_0_wdata, rf_bus_1_wdata;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter dut (
        .clock(clock), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .alu0_valid(alu0_valid), .alu0_ready(alu0_ready), .alu0_rd(alu0_rd), .alu0_data(alu0_data),
        .alu1_valid(alu1_valid), .alu1_ready(alu1_ready), .alu1_rd(alu1_rd), .alu1_data(alu1_data),
        .rf_bus_0_wen(rf_bus_0_wen), .rf_bus_0_waddr(rf_bus_0_waddr), .rf_bus_0_wdata(rf_bus_0_wdata),
        .rf_bus_1_wen(rf_bus_1_wen), .rf_bus_1_waddr(rf_bus_1_waddr), .rf_bus_1_wdata(rf_bus_1_wdata),
        .wb_idle(wb_idle)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2);
        lsu_valid = v[0]; alu0_valid = v[1]; alu1_valid = v[2];
        lsu_rd = r0; alu0_rd = r1; alu1_rd = r2;
        lsu_data = d0; alu0_data = d1; alu1_data = d2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Directed vector: sources offered once; expected source index per output (3 = no grant).
    typedef struct {
        logic [2:0]  v;
        logic [4:0]  r0, r1, r2;
        logic [63:0] d0, d1, d2;
        int          c1p0, c1p1, c2p0;
    } vec_t;

    vec_t        vecs [6];
    logic [4:0]  t_rd [4];
    logic [63:0] t_d [4];

    task automatic chk_port(input string tag, input int p, input int src);
        logic        w;
        logic [4:0]  a;
        logic [63:0] d;
        if (p == 0) begin w = rf_bus_0_wen; a = rf_bus_0_waddr; d = rf_bus_0_wdata; end
        else        begin w = rf_bus_1_wen; a = rf_bus_1_waddr; d = rf_bus_1_wdata; end
        chk({tag, "_wen"},   w, t_rd[src] != 5'd0);
        chk({tag, "_waddr"}, a, t_rd[src]);
        chk({tag, "_wdata"}, d, t_d[src]);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_lsu_ready"},  lsu_ready,  1'b1);
        chk({tag, "_alu0_ready"}, alu0_ready, 1'b1);
        chk({tag, "_alu1_ready"}, alu1_ready, 1'b1);
        chk({tag, "_wb_idle"},    wb_idle,    1'b1);
    endtask

    // Reference model state
    bit          m_held [3];
    logic [4:0]  m_rd [3];
    logic [63:0] m_d [3];
    int          m_wait;
    logic        e_wen [2];
    logic [4:0]  e_addr [2];
    logic [63:0] e_data [2];

    // Port 0 takes the first held source in priority order; port 1 the next one
    // that does not target port 0's nonzero destination.
    task automatic model_grants(output int g0, output int g1);
        int pri[$];
        int avail[$];
        pri = '{0, 1, 2};
        if (m_wait == 3) pri = '{0, 2, 1};
        foreach (pri[k]) if (m_held[pri[k]]) avail.push_back(pri[k]);
        g0 = -1;
        g1 = -1;
        if (avail.size() > 0) g0 = avail.pop_front();
        while (avail.size() > 0 && g1 < 0) begin
            int c;
            c = avail.pop_front();
            if (m_rd[c] == 5'd0 || m_rd[c] != m_rd[g0]) g1 = c;
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin m_held[s] = 0; m_rd[s] = 5'd0; m_d[s] = 64'd0; end
        m_wait = 0;
        for (int p = 0; p < 2; p++) begin e_wen[p] = 1'b0; e_addr[p] = 5'd0; e_data[p] = 64'd0; end
    endtask

    initial begin
        int g [2];
        bit rdy [3];
        bit vld [3];
        bit rst_now;
        logic [4:0]  nr [3];
        logic [63:0] nd [3];
        int since [3];

        vecs[0] = '{3'b010, 5'd0, 5'd5, 5'd0, 64'd0, 64'h1234, 64'd0, 1, 3, 3};
        vecs[1] = '{3'b111, 5'd3, 5'd4, 5'd6, 64'hA3, 64'hA4, 64'hA6, 0, 1, 2};
        vecs[2] = '{3'b111, 5'd7, 5'd7, 5'd8, 64'hB7, 64'hC7, 64'hB8, 0, 2, 1};
        vecs[3] = '{3'b100, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h55AA, 2, 3, 3};
        vecs[4] = '{3'b111, 5'd0, 5'd0, 5'd9, 64'hD0, 64'hD1, 64'hD9, 0, 1, 2};
        vecs[5] = '{3'b001, 5'd31, 5'd0, 5'd0, 64'hFFFF_0000_1111_2222, 64'd0, 64'd0, 0, 3, 3};

        do_reset();
        chk("reset_wen0", rf_bus_0_wen, 1'b0);
        chk("reset_wen1", rf_bus_1_wen, 1'b0);
        chk_quiet("reset");

        // Table-driven single-shot transactions
        for (int i = 0; i < 6; i++) begin
            do_reset();
            t_rd[0] = vecs[i].r0; t_rd[1] = vecs[i].r1; t_rd[2] = vecs[i].r2; t_rd[3] = 5'd0;
            t_d[0]  = vecs[i].d0; t_d[1]  = vecs[i].d1; t_d[2]  = vecs[i].d2; t_d[3]  = 64'd0;
            drive(vecs[i].v, vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            @(negedge clock);
            drive(3'b000, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0);
            chk_port($sformatf("v%0d_c0_p0", i), 0, 3);
            @(negedge clock);
            chk_port($sformatf("v%0d_c1_p0", i), 0, vecs[i].c1p0);
            chk_port($sformatf("v%0d_c1_p1", i), 1, vecs[i].c1p1);
            @(negedge clock);
            chk_port($sformatf("v%0d_c2_p0", i), 0, vecs[i].c2p0);
            chk_port($sformatf("v%0d_c2_p1", i), 1, 3);
            @(negedge clock);
            chk_port($sformatf("v%0d_c3_p0", i), 0, 3);
            chk_port($sformatf("v%0d_c3_p1", i), 1, 3);
            chk_quiet($sformatf("v%0d_c3", i));
        end

        // All three continuously valid: nobody may go more than 3 output cycles unseen
        do_reset();
        drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33);
        for (int s = 0; s < 3; s++) since[s] = 0;
        @(negedge clock);
        for (int c = 1; c < 40; c++) begin
            @(negedge clock);
            for (int s = 0; s < 3; s++) begin
                if ((rf_bus_0_wen && rf_bus_0_waddr == 5'(s + 1)) ||
                    (rf_bus_1_wen && rf_bus_1_waddr == 5'(s + 1))) since[s] = 0;
                else since[s]++;
                chk($sformatf("starve_c%0d_s%0d", c, s), since[s] <= 3, 1'b1);
            end
        end

        // Reset while all three are held, with valids still offered during reset
        do_reset();
        drive(3'b111, 5'd10, 5'd11, 5'd12, 64'h1, 64'h2, 64'h3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0);
        chk_quiet("midrst");
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("midrst_c%0d_wen0", c), rf_bus_0_wen, 1'b0);
            chk($sformatf("midrst_c%0d_wen1", c), rf_bus_1_wen, 1'b0);
            chk($sformatf("midrst_c%0d_idle", c), wb_idle, 1'b1);
            @(negedge clock);
        end

        // Randomized traffic against the reference model
        do_reset();
        model_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            model_grants(g[0], g[1]);
            for (int s = 0; s < 3; s++) rdy[s] = !m_held[s] || s == g[0] || s == g[1];
            chk("rnd_wen0",   rf_bus_0_wen,   e_wen[0]);
            chk("rnd_waddr0", rf_bus_0_waddr, e_addr[0]);
            chk("rnd_wdata0", rf_bus_0_wdata, e_data[0]);
            chk("rnd_wen1",   rf_bus_1_wen,   e_wen[1]);
            chk("rnd_waddr1", rf_bus_1_waddr, e_addr[1]);
            chk("rnd_wdata1", rf_bus_1_wdata, e_data[1]);
            chk("rnd_lsu_ready",  lsu_ready,  rdy[0]);
            chk("rnd_alu0_ready", alu0_ready, rdy[1]);
            chk("rnd_alu1_ready", alu1_ready, rdy[2]);
            chk("rnd_wb_idle", wb_idle,
                !m_held[0] && !m_held[1] && !m_held[2] && !e_wen[0] && !e_wen[1]);

            rst_now = ($urandom_range(0, 63) == 0);
            for (int s = 0; s < 3; s++) begin
                vld[s] = ($urandom_range(0, 9) < 6);
                nr[s]  = 5'($urandom_range(0, 7));
                nd[s]  = {$urandom, $urandom};
            end
            reset = rst_now;
            drive({vld[2], vld[1], vld[0]}, nr[0], nr[1], nr[2], nd[0], nd[1], nd[2]);

            if (rst_now) begin
                model_clear();
            end else begin
                for (int p = 0; p < 2; p++) begin
                    e_wen[p]  = (g[p] >= 0) && (m_rd[g[p]] != 5'd0);
                    e_addr[p] = (g[p] >= 0) ? m_rd[g[p]] : 5'd0;
                    e_data[p] = (g[p] >= 0) ? m_d[g[p]]  : 64'd0;
                end
                if (m_held[2] && g[0] != 2 && g[1] != 2) m_wait = (m_wait < 3) ? m_wait + 1 : 3;
                else m_wait = 0;
                for (int s = 0; s < 3; s++) begin
                    if (vld[s] && rdy[s]) begin
                        m_held[s] = 1; m_rd[s] = nr[s]; m_d[s] = nd[s];
                    end else if (s == g[0] || s == g[1]) begin
                        m_held[s] = 0;
                    end
                end
            end
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
